// File: rtl/modrm_sib_encoder.sv
`default_nettype none
// ============================================================================
// Module      : modrm_sib_encoder
// Description : Serialising ModR/M encoder. Accepts one decoded
//               effective-address description per request handshake and
//               emits the ModR/M byte, an optional SIB byte and the
//               little-endian displacement bytes, one byte per cycle, on a
//               valid/ready byte stream. Inverse of decode_mod_rm.
//
// Ports       : clk, rst_n (async, active-low)
//               req_valid/req_ready       request handshake
//               bit_width                 0 = 16-bit, 1 = 32-bit addressing
//               reg_field, rm_is_reg      ModR/M reg field, register operand
//               base_en/base_reg          base register
//               index_en/index_reg/scale  index register and SIB scale
//               displacement              signed displacement
//               out_valid/out_ready       byte stream handshake
//               out_byte/out_last         byte and end-of-encoding marker
//               err                       one-cycle illegal-request pulse
//
// Options     : MODRM_ENC_DISP8_EN - when defined, the shortest displacement
//               form (mod=01 disp8) is used when the value fits; otherwise
//               every displacement is full width (mod=10).
//
// Revision    : 1.0 - initial release
// ============================================================================
module modrm_sib_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        bit_width,
    input  logic [2:0]  reg_field,
    input  logic        rm_is_reg,
    input  logic        base_en,
    input  logic [2:0]  base_reg,
    input  logic        index_en,
    input  logic [2:0]  index_reg,
    input  logic [1:0]  scale,
    input  logic [31:0] displacement,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic        err
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_MODRM = 3'd1;
    localparam logic [2:0] ST_SIB   = 3'd2;
    localparam logic [2:0] ST_DISP  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    // GPR encodings that carry special meaning in the address forms
    localparam logic [2:0] C_ESP = 3'b100;
    localparam logic [2:0] C_EBP = 3'b101;
    localparam logic [2:0] C_BX  = 3'b011;
    localparam logic [2:0] C_BP  = 3'b101;
    localparam logic [2:0] C_SI  = 3'b110;
    localparam logic [2:0] C_DI  = 3'b111;

    // ------------------------------------------------------------------
    // Request decode (combinational, only consumed at accept)
    // ------------------------------------------------------------------
    logic       w_err;
    logic [2:0] w_rm;
    logic       w_has_sib;
    logic [7:0] w_sib;
    logic       w_absolute;   // no base: mod=00 with full-width displacement
    logic       w_bp_base;    // EBP/BP base: mod=00 would mean "no base"
    logic [1:0] w_mod;
    logic       w_has_disp;
    logic [1:0] w_len_m1;
    logic       w_disp_zero;
    logic       w_disp_fits8;
    logic [1:0] w_full_len_m1;
    logic       w_accept;

    assign w_accept      = req_valid && req_ready;
    assign w_full_len_m1 = bit_width ? 2'd3 : 2'd1;
    assign w_disp_zero   = bit_width ? (displacement == 32'd0)
                                     : (displacement[15:0] == 16'd0);
    // Fits in signed 8 bits when every bit from 7 upward matches the sign
    assign w_disp_fits8  = bit_width
        ? ((&displacement[31:7]) || !(|displacement[31:7]))
        : ((&displacement[15:7]) || !(|displacement[15:7]));

    always_comb begin
        w_err      = 1'b0;
        w_rm       = 3'b000;
        w_has_sib  = 1'b0;
        w_sib      = 8'h00;
        w_absolute = 1'b0;
        w_bp_base  = 1'b0;

        if (rm_is_reg) begin
            w_rm = base_reg;
        end else if (bit_width) begin
            if (!base_en && !index_en) begin
                w_rm       = C_EBP;
                w_absolute = 1'b1;
            end else if (index_en || (base_reg == C_ESP)) begin
                // SIB form; index code 100 means "no index" so cannot be used
                w_rm      = C_ESP;
                w_has_sib = 1'b1;
                w_err     = index_en && (index_reg == C_ESP);
                w_sib     = {(index_en ? scale : 2'b00),
                             (index_en ? index_reg : C_ESP),
                             (base_en ? base_reg : C_EBP)};
                w_absolute = !base_en;
                w_bp_base  = base_en && (base_reg == C_EBP);
            end else begin
                w_rm      = base_reg;
                w_bp_base = (base_reg == C_EBP);
            end
        end else begin
            if (base_en && index_en) begin
                if (((base_reg == C_BX) || (base_reg == C_BP)) &&
                    ((index_reg == C_SI) || (index_reg == C_DI))) begin
                    w_rm = {1'b0, (base_reg == C_BP), (index_reg == C_DI)};
                end else begin
                    w_err = 1'b1;
                end
            end else if (base_en) begin
                case (base_reg)
                    C_SI:    w_rm = 3'b100;
                    C_DI:    w_rm = 3'b101;
                    C_BP: begin
                        w_rm      = 3'b110;
                        w_bp_base = 1'b1;
                    end
                    C_BX:    w_rm = 3'b111;
                    default: w_err = 1'b1;
                endcase
            end else if (index_en) begin
                case (index_reg)
                    C_SI:    w_rm = 3'b100;
                    C_DI:    w_rm = 3'b101;
                    default: w_err = 1'b1;
                endcase
            end else begin
                w_rm       = 3'b110;
                w_absolute = 1'b1;
            end
        end
    end

    // Mod and displacement length selection
    always_comb begin
        w_mod      = 2'b10;
        w_has_disp = 1'b1;
        w_len_m1   = w_full_len_m1;
        if (rm_is_reg) begin
            w_mod      = 2'b11;
            w_has_disp = 1'b0;
            w_len_m1   = 2'd0;
        end else if (w_absolute) begin
            w_mod = 2'b00;
        end else if (w_disp_zero && !w_bp_base) begin
            w_mod      = 2'b00;
            w_has_disp = 1'b0;
            w_len_m1   = 2'd0;
        end
`ifdef MODRM_ENC_DISP8_EN
        else if (w_disp_fits8) begin
            w_mod    = 2'b01;
            w_len_m1 = 2'd0;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [7:0]  r_modrm;
    logic [7:0]  r_sib;
    logic        r_has_sib;
    logic        r_has_disp;
    logic [1:0]  r_len_m1;
    logic [1:0]  r_cnt;
    logic [31:0] r_disp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_modrm    <= 8'h00;
            r_sib      <= 8'h00;
            r_has_sib  <= 1'b0;
            r_has_disp <= 1'b0;
            r_len_m1   <= 2'd0;
            r_cnt      <= 2'd0;
            r_disp     <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_modrm    <= {w_mod, reg_field, w_rm};
                        r_sib      <= w_sib;
                        r_has_sib  <= w_has_sib && !rm_is_reg;
                        r_has_disp <= w_has_disp;
                        r_len_m1   <= w_len_m1;
                        r_cnt      <= 2'd0;
                        r_disp     <= displacement;
                        r_state    <= (w_err && !rm_is_reg) ? ST_ERR : ST_MODRM;
                    end
                end
                ST_MODRM: begin
                    if (out_ready) begin
                        if (r_has_sib)       r_state <= ST_SIB;
                        else if (r_has_disp) r_state <= ST_DISP;
                        else                 r_state <= ST_IDLE;
                    end
                end
                ST_SIB: begin
                    if (out_ready) begin
                        r_state <= r_has_disp ? ST_DISP : ST_IDLE;
                    end
                end
                ST_DISP: begin
                    if (out_ready) begin
                        if (r_cnt == r_len_m1) r_state <= ST_IDLE;
                        else                   r_cnt   <= r_cnt + 2'd1;
                    end
                end
                ST_ERR:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state so they hold during stalls
    // ------------------------------------------------------------------
    assign req_ready = (r_state == ST_IDLE);
    assign err       = (r_state == ST_ERR);
    assign out_valid = (r_state == ST_MODRM) || (r_state == ST_SIB) ||
                       (r_state == ST_DISP);

    always_comb begin
        out_byte = 8'h00;
        out_last = 1'b0;
        case (r_state)
            ST_MODRM: begin
                out_byte = r_modrm;
                out_last = !r_has_sib && !r_has_disp;
            end
            ST_SIB: begin
                out_byte = r_sib;
                out_last = !r_has_disp;
            end
            ST_DISP: begin
                case (r_cnt)
                    2'd0:    out_byte = r_disp[7:0];
                    2'd1:    out_byte = r_disp[15:8];
                    2'd2:    out_byte = r_disp[23:16];
                    default: out_byte = r_disp[31:24];
                endcase
                out_last = (r_cnt == r_len_m1);
            end
            default: begin
                out_byte = 8'h00;
                out_last = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_modrm_sib_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_modrm_sib_encoder
// Description : Directed self-checking bench for modrm_sib_encoder. Expected
//               byte sequences are hand-encoded; the MODRM_ENC_DISP8_EN
//               build selects the matching expectation set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modrm_sib_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        bit_width = 1'b0;
    logic [2:0]  reg_field = 3'b000;
    logic        rm_is_reg = 1'b0;
    logic        base_en = 1'b0;
    logic [2:0]  base_reg = 3'b000;
    logic        index_en = 1'b0;
    logic [2:0]  index_reg = 3'b000;
    logic [1:0]  scale = 2'b00;
    logic [31:0] displacement = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        err;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic [7:0] rx_byte [0:7];
    logic       rx_last [0:7];
    int         rx_n;
    int         rx_first;
    bit         rx_timeout;

    modrm_sib_encoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .bit_width    (bit_width),
        .reg_field    (reg_field),
        .rm_is_reg    (rm_is_reg),
        .base_en      (base_en),
        .base_reg     (base_reg),
        .index_en     (index_en),
        .index_reg    (index_reg),
        .scale        (scale),
        .displacement (displacement),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_byte     (out_byte),
        .out_last     (out_last),
        .err          (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    // Called just after a negedge while idle: presents one request, lets it be
    // accepted on the next rising edge, then scrambles the inputs.
    task automatic send(input logic bw, input logic [2:0] rf, input logic rr,
                        input logic be, input logic [2:0] br,
                        input logic ie, input logic [2:0] ir,
                        input logic [1:0] sc, input logic [31:0] d);
        bit_width    = bw;
        reg_field    = rf;
        rm_is_reg    = rr;
        base_en      = be;
        base_reg     = br;
        index_en     = ie;
        index_reg    = ir;
        scale        = sc;
        displacement = d;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        bit_width    = ~bw;
        reg_field    = 3'b111;
        rm_is_reg    = 1'b0;
        base_en      = 1'b1;
        base_reg     = 3'b000;
        index_en     = 1'b1;
        index_reg    = 3'b100;
        scale        = 2'b01;
        displacement = 32'hA5A5_A5A5;
    endtask

    // Captures the byte stream with out_ready held high (no comparisons).
    task automatic receive();
        bit done = 1'b0;
        rx_n       = 0;
        rx_first   = -1;
        rx_timeout = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rx_byte[i] = 8'hxx;
            rx_last[i] = 1'bx;
        end
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (out_valid && rx_n < 8) begin
                if (rx_first < 0) rx_first = c;
                rx_byte[rx_n] = out_byte;
                rx_last[rx_n] = out_last;
                rx_n++;
                if (out_last) done = 1'b1;
            end
        end
        if (!done) rx_timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if (req_ready !== 1'b1) begin miss_cnt++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        vec_cnt++;
        if (out_valid !== 1'b0) begin miss_cnt++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vec_cnt++;
        if (out_byte !== 8'h00) begin miss_cnt++; $display("FAIL reset_out_byte: got %h want 00", out_byte); end
        vec_cnt++;
        if (out_last !== 1'b0) begin miss_cnt++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        vec_cnt++;
        if (err !== 1'b0) begin miss_cnt++; $display("FAIL reset_err: got %b want 0", err); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sib32();
        logic [7:0] exp_b [0:5];
        int exp_n;
`ifdef MODRM_ENC_DISP8_EN
        exp_b = '{8'h44, 8'hF3, 8'h20, 8'h00, 8'h00, 8'h00}; exp_n = 3;
`else
        exp_b = '{8'h84, 8'hF3, 8'h20, 8'h00, 8'h00, 8'h00}; exp_n = 6;
`endif
        send(1'b1, 3'b000, 1'b0, 1'b1, 3'b011, 1'b1, 3'b110, 2'b11, 32'h20);
        receive();
        vec_cnt++;
        if (rx_first !== 0) begin miss_cnt++; $display("FAIL sib32_latency: first byte at cycle %0d want 0", rx_first); end
        vec_cnt++;
        if (rx_timeout || rx_n !== exp_n) begin miss_cnt++; $display("FAIL sib32_len: got %0d bytes timeout=%0b want %0d", rx_n, rx_timeout, exp_n); end
        for (int i = 0; i < exp_n; i++) begin
            vec_cnt++;
            if (rx_byte[i] !== exp_b[i] || rx_last[i] !== (i == exp_n - 1)) begin
                miss_cnt++;
                $display("FAIL sib32_byte%0d: got %h last=%b want %h last=%b", i, rx_byte[i], rx_last[i], exp_b[i], (i == exp_n - 1));
            end
        end
        @(negedge clk);
        vec_cnt++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0) begin miss_cnt++; $display("FAIL sib32_idle: got ready=%b valid=%b want 1 0", req_ready, out_valid); end
    endtask

    task automatic test_addr16();
        logic [7:0] exp_b [0:5];
        int exp_n;
        // BX+SI + 6
`ifdef MODRM_ENC_DISP8_EN
        exp_b = '{8'h40, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00}; exp_n = 2;
`else
        exp_b = '{8'h80, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00}; exp_n = 3;
`endif
        send(1'b0, 3'b000, 1'b0, 1'b1, 3'b011, 1'b1, 3'b110, 2'b00, 32'h6);
        receive();
        vec_cnt++;
        if (rx_timeout || rx_n !== exp_n) begin miss_cnt++; $display("FAIL bxsi16_len: got %0d bytes timeout=%0b want %0d", rx_n, rx_timeout, exp_n); end
        for (int i = 0; i < exp_n; i++) begin
            vec_cnt++;
            if (rx_byte[i] !== exp_b[i] || rx_last[i] !== (i == exp_n - 1)) begin
                miss_cnt++;
                $display("FAIL bxsi16_byte%0d: got %h last=%b want %h last=%b", i, rx_byte[i], rx_last[i], exp_b[i], (i == exp_n - 1));
            end
        end
        @(negedge clk);
        // [BP] alone with zero displacement, reg=010
`ifdef MODRM_ENC_DISP8_EN
        exp_b = '{8'h56, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; exp_n = 2;
`else
        exp_b = '{8'h96, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; exp_n = 3;
`endif
        send(1'b0, 3'b010, 1'b0, 1'b1, 3'b101, 1'b0, 3'b000, 2'b00, 32'h0);
        receive();
        vec_cnt++;
        if (rx_timeout || rx_n !== exp_n) begin miss_cnt++; $display("FAIL bp16_len: got %0d bytes timeout=%0b want %0d", rx_n, rx_timeout, exp_n); end
        for (int i = 0; i < exp_n; i++) begin
            vec_cnt++;
            if (rx_byte[i] !== exp_b[i] || rx_last[i] !== (i == exp_n - 1)) begin
                miss_cnt++;
                $display("FAIL bp16_byte%0d: got %h last=%b want %h last=%b", i, rx_byte[i], rx_last[i], exp_b[i], (i == exp_n - 1));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_ebp_esp();
        logic [7:0] exp_b [0:5];
        int exp_n;
        // [EBP], disp 0
`ifdef MODRM_ENC_DISP8_EN
        exp_b = '{8'h45, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; exp_n = 2;
`else
        exp_b = '{8'h85, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; exp_n = 5;
`endif
        send(1'b1, 3'b000, 1'b0, 1'b1, 3'b101, 1'b0, 3'b000, 2'b00, 32'h0);
        receive();
        vec_cnt++;
        if (rx_timeout || rx_n !== exp_n) begin miss_cnt++; $display("FAIL ebp_len: got %0d bytes timeout=%0b want %0d", rx_n, rx_timeout, exp_n); end
        for (int i = 0; i < exp_n; i++) begin
            vec_cnt++;
            if (rx_byte[i] !== exp_b[i] || rx_last[i] !== (i == exp_n - 1)) begin
                miss_cnt++;
                $display("FAIL ebp_byte%0d: got %h last=%b want %h last=%b", i, rx_byte[i], rx_last[i], exp_b[i], (i == exp_n - 1));
            end
        end
        @(negedge clk);
        // [ESP], disp 0: same in both builds
        exp_b = '{8'h04, 8'h24, 8'h00, 8'h00, 8'h00, 8'h00}; exp_n = 2;
        send(1'b1, 3'b000, 1'b0, 1'b1, 3'b100, 1'b0, 3'b000, 2'b00, 32'h0);
        receive();
        vec_cnt++;
        if (rx_timeout || rx_n !== exp_n) begin miss_cnt++; $display("FAIL esp_len: got %0d bytes timeout=%0b want %0d", rx_n, rx_timeout, exp_n); end
        for (int i = 0; i < exp_n; i++) begin
            vec_cnt++;
            if (rx_byte[i] !== exp_b[i] || rx_last[i] !== (i == exp_n - 1)) begin
                miss_cnt++;
                $display("FAIL esp_byte%0d: got %h last=%b want %h last=%b", i, rx_byte[i], rx_last[i], exp_b[i], (i == exp_n - 1));
            end
        end
        @(negedge clk);
        // [EAX-2], reg=011: negative disp8 boundary
`ifdef MODRM_ENC_DISP8_EN
        exp_b = '{8'h58, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00}; exp_n = 2;
`else
        exp_b = '{8'h98, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'h00}; exp_n = 5;
`endif
        send(1'b1, 3'b011, 1'b0, 1'b1, 3'b000, 1'b0, 3'b000, 2'b00, 32'hFFFF_FFFE);
        receive();
        vec_cnt++;
        if (rx_timeout || rx_n !== exp_n) begin miss_cnt++; $display("FAIL neg8_len: got %0d bytes timeout=%0b want %0d", rx_n, rx_timeout, exp_n); end
        for (int i = 0; i < exp_n; i++) begin
            vec_cnt++;
            if (rx_byte[i] !== exp_b[i] || rx_last[i] !== (i == exp_n - 1)) begin
                miss_cnt++;
                $display("FAIL neg8_byte%0d: got %h last=%b want %h last=%b", i, rx_byte[i], rx_last[i], exp_b[i], (i == exp_n - 1));
            end
        end
        @(negedge clk);
    endtask

    // disp32 absolute with out_ready pattern 1,0,0 repeating
    task automatic test_abs_stall();
        logic [7:0] exp_b [0:4];
        logic       pat [0:2];
        logic [7:0] held_b;
        logic       held_l;
        bit         held;
        int         ntx;
        int         k;
        exp_b = '{8'h0D, 8'h78, 8'h56, 8'h34, 8'h12};
        pat   = '{1'b1, 1'b0, 1'b0};
        held  = 1'b0;
        held_b = 8'h00;
        held_l = 1'b0;
        ntx = 0;
        k = 0;
        send(1'b1, 3'b001, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 2'b00, 32'h1234_5678);
        for (int c = 0; c < 40 && ntx < 5; c++) begin
            @(negedge clk);
            out_ready = pat[k];
            k = (k + 1) % 3;
            if (out_valid) begin
                if (held) begin
                    vec_cnt++;
                    if (out_byte !== held_b || out_last !== held_l) begin
                        miss_cnt++;
                        $display("FAIL stall_hold: got %h last=%b want %h last=%b", out_byte, out_last, held_b, held_l);
                    end
                end
                if (out_ready) begin
                    vec_cnt++;
                    if (out_byte !== exp_b[ntx] || out_last !== (ntx == 4)) begin
                        miss_cnt++;
                        $display("FAIL stall_byte%0d: got %h last=%b want %h last=%b", ntx, out_byte, out_last, exp_b[ntx], (ntx == 4));
                    end
                    ntx++;
                end
                held   = !out_ready;
                held_b = out_byte;
                held_l = out_last;
            end else begin
                held = 1'b0;
            end
        end
        vec_cnt++;
        if (ntx !== 5) begin miss_cnt++; $display("FAIL stall_count: got %0d transfers want 5", ntx); end
        @(negedge clk);
        out_ready = 1'b1;
        vec_cnt++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0) begin miss_cnt++; $display("FAIL stall_idle: got ready=%b valid=%b want 1 0", req_ready, out_valid); end
    endtask

    task automatic test_errors();
        // 32-bit with index register ESP
        send(1'b1, 3'b000, 1'b0, 1'b1, 3'b000, 1'b1, 3'b100, 2'b00, 32'h0);
        @(negedge clk);
        vec_cnt++;
        if (err !== 1'b1 || out_valid !== 1'b0 || req_ready !== 1'b0) begin miss_cnt++; $display("FAIL err32_pulse: got err=%b valid=%b ready=%b want 1 0 0", err, out_valid, req_ready); end
        @(negedge clk);
        vec_cnt++;
        if (err !== 1'b0 || out_valid !== 1'b0 || req_ready !== 1'b1) begin miss_cnt++; $display("FAIL err32_after: got err=%b valid=%b ready=%b want 0 0 1", err, out_valid, req_ready); end
        // 16-bit with AX as base
        send(1'b0, 3'b000, 1'b0, 1'b1, 3'b000, 1'b0, 3'b000, 2'b00, 32'h0);
        @(negedge clk);
        vec_cnt++;
        if (err !== 1'b1 || out_valid !== 1'b0) begin miss_cnt++; $display("FAIL err16_pulse: got err=%b valid=%b want 1 0", err, out_valid); end
        @(negedge clk);
        vec_cnt++;
        if (err !== 1'b0 || out_valid !== 1'b0 || req_ready !== 1'b1) begin miss_cnt++; $display("FAIL err16_after: got err=%b valid=%b ready=%b want 0 0 1", err, out_valid, req_ready); end
    endtask

    task automatic test_async_reset();
        logic [7:0] exp_b [0:5];
        int exp_n;
        send(1'b1, 3'b000, 1'b0, 1'b1, 3'b011, 1'b1, 3'b110, 2'b11, 32'h20);
        @(negedge clk);   // ModR/M shown, transfers on next edge
        @(negedge clk);   // SIB shown
        vec_cnt++;
        if (out_valid !== 1'b1 || out_byte !== 8'hF3) begin miss_cnt++; $display("FAIL arst_presib: got valid=%b byte=%h want 1 f3", out_valid, out_byte); end
        #2 rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1 || out_byte !== 8'h00 || out_last !== 1'b0 || err !== 1'b0) begin
            miss_cnt++;
            $display("FAIL arst_immediate: got valid=%b ready=%b byte=%h last=%b err=%b want 0 1 00 0 0", out_valid, req_ready, out_byte, out_last, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_b = '{8'h04, 8'h24, 8'h00, 8'h00, 8'h00, 8'h00}; exp_n = 2;
        send(1'b1, 3'b000, 1'b0, 1'b1, 3'b100, 1'b0, 3'b000, 2'b00, 32'h0);
        receive();
        vec_cnt++;
        if (rx_timeout || rx_n !== exp_n) begin miss_cnt++; $display("FAIL arst_len: got %0d bytes timeout=%0b want %0d", rx_n, rx_timeout, exp_n); end
        for (int i = 0; i < exp_n; i++) begin
            vec_cnt++;
            if (rx_byte[i] !== exp_b[i] || rx_last[i] !== (i == exp_n - 1)) begin
                miss_cnt++;
                $display("FAIL arst_byte%0d: got %h last=%b want %h last=%b", i, rx_byte[i], rx_last[i], exp_b[i], (i == exp_n - 1));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        // Register-direct: 11 010 001
        send(1'b1, 3'b010, 1'b1, 1'b0, 3'b001, 1'b0, 3'b000, 2'b00, 32'h0);
        receive();
        vec_cnt++;
        if (rx_timeout || rx_n !== 1 || rx_byte[0] !== 8'hD1 || rx_last[0] !== 1'b1) begin
            miss_cnt++;
            $display("FAIL b2b_regdirect: got n=%0d byte=%h last=%b want 1 d1 1", rx_n, rx_byte[0], rx_last[0]);
        end
        @(negedge clk);
        vec_cnt++;
        if (req_ready !== 1'b1) begin miss_cnt++; $display("FAIL b2b_ready: got %b want 1", req_ready); end
        // Immediately follow with 16-bit absolute disp16 = 0x1234
        send(1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 2'b00, 32'hFFFF_1234);
        receive();
        vec_cnt++;
        if (rx_timeout || rx_n !== 3) begin miss_cnt++; $display("FAIL b2b_abs16_len: got %0d bytes timeout=%0b want 3", rx_n, rx_timeout); end
        vec_cnt++;
        if (rx_byte[0] !== 8'h06 || rx_byte[1] !== 8'h34 || rx_byte[2] !== 8'h12 || rx_last[2] !== 1'b1 || rx_last[1] !== 1'b0) begin
            miss_cnt++;
            $display("FAIL b2b_abs16_bytes: got %h %h %h last=%b want 06 34 12 last=1", rx_byte[0], rx_byte[1], rx_byte[2], rx_last[2]);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_sib32();
        test_addr16();
        test_ebp_esp();
        test_abs_stall();
        test_errors();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/modrm_sib_encoder.md
# modrm_sib_encoder

Serialising ModR/M encoder: accepts one decoded effective-address description per handshake and emits the ModR/M byte, the optional SIB byte and the displacement bytes, one byte per cycle, on a valid/ready byte stream. It is the inverse of decode_mod_rm. Uses:
- Instruction-stream generator for front-end verification: its bytes feed the prefetch queue and decode_mod_rm, and the bench checks the round-trip.
- Microcode assembly helper.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- bit_width  in  1  0 selects 16-bit addressing, 1 selects 32-bit addressing.
- reg_field  in  3  value of the ModR/M reg/opcode field.
- rm_is_reg  in  1  register-direct operand; produces mod=11 with r/m=base_reg.
- base_en  in  1  base register present.
- base_reg  in  3  GPR encoding of the base register.
- index_en  in  1  index register present.
- index_reg  in  3  GPR encoding of the index register.
- scale  in  2  SIB scale field (log2 of the multiplier).
- displacement  in  32  signed displacement; only bits [15:0] are used when bit_width=0.
- out_valid  out  1  out_byte is valid.
- out_ready  in  1  consumer accepts the byte.
- out_byte  out  8  current output byte.
- out_last  out  1  marks the final byte of the encoding.
- err  out  1  one-cycle pulse; the request was illegal and is dropped.

## Operation
- FSM states: IDLE, MODRM, SIB, DISP, ERR.
- Inputs are sampled only at accept and registered. The caller may change the inputs after the accept cycle.
- rm_is_reg: emit one byte {2'b11, reg_field, base_reg}.
- 32-bit addressing:
  - A SIB byte is required when index_en is set, when base_reg=100, or when there is no base and an index is present. r/m is then 100.
  - index_en with index_reg=100 is an error.
  - No base and no index: mod=00, r/m=101, disp32.
  - SIB with no base: mod=00, SIB base=101, disp32.
  - SIB index field is 100 when there is no index.
- 16-bit addressing:
  - Legal r/m codes: BX+SI=000, BX+DI=001, BP+SI=010, BP+DI=011, SI=100, DI=101, BP=110, BX=111.
  - No base and no index: mod=00, r/m=110, disp16.
  - Any other base/index combination is an error.
- Mod selection (with DISP8 enabled):
  - Displacement 0 and base is not EBP/BP: mod=00.
  - Displacement fits signed 8 bits (disp[31:7] or disp[15:7] all equal): mod=01.
  - Otherwise: mod=10.
  - A base of EBP/BP with displacement 0 uses mod=01 with disp8=00.
- Displacement bytes are emitted little-endian. A 2-bit counter counts 0..(len-1).
- Encoding length is 1 to 6 bytes. out_last is set on the final byte.

## Timing
- Reset values: state=IDLE, req_ready=1, out_valid=0, out_byte=8'h00, out_last=0, err=0.
- Latency: the first byte is valid on the cycle after accept. One byte is transferred per cycle while out_ready=1.
- When out_valid=1 and out_ready=0, out_byte and out_last hold stable.
- The cycle after the last byte is accepted: IDLE with req_ready=1. The next request can be accepted in that cycle, so back-to-back requests have a one-cycle gap.
- On an illegal request, err=1 for exactly the one cycle after accept (ERR state). No bytes are emitted and the FSM returns to IDLE.
- Async reset mid-stream: immediate return to reset values; the partial encoding is discarded.
- req_valid while not in IDLE is ignored (req_ready=0).

## Configuration
- MODRM_ENC_DISP8_EN defined: shortest displacement form, using mod=00/01/10 as described in Operation.
- Not defined: no disp8 form at all.
  - Zero displacement with a base other than EBP/BP still uses mod=00.
  - Any nonzero displacement, and the EBP/BP-base case, uses mod=10 with full width (disp16/disp32).
  - Example: [EBP] encodes as 85 00 00 00 00.
- Scenario values below assume the macro is defined unless stated otherwise.

## Test plan
- 32-bit, reg=000, base=011, index=110, scale=11, disp=0x20 -> bytes 44 F3 20; out_last on 20. Without the macro: 84 F3 20 00 00 00.
- 16-bit, reg=000, base=011 (BX), index=110 (SI), disp=6 -> 40 06.
- 32-bit, reg=000, base=101 (EBP), disp=0 -> 45 00. Base=100 (ESP), disp=0 -> 04 24.
- 32-bit, reg=001, no base, no index, disp=0x12345678 -> 0D 78 56 34 12. With out_ready toggled 1,0,0,1,...: each byte held stable while stalled; 5 transfers total.
- 32-bit, index_en=1 with index_reg=100 -> err pulse of exactly 1 cycle, out_valid stays 0, req_ready=1 the following cycle. 16-bit base=000 (AX) -> same err response.
- Assert rst_n low during the SIB byte of scenario 1 -> out_valid=0 immediately; after release, a new request encodes correctly from its first byte.
